reorder_buffer: RTL

Circular reorder buffer for the out-of-order core. It accepts entry allocations from the decode stage and returns the allocated tail index. Each entry's result is captured from the writeback bus, and the decoder's operand-tag queries are answered combinationally. Entries retire strictly in program order, one per cycle, to the register file. A flush port squashes every in-flight entry on a branch mispredict.

---
 rtl/reorder_buffer_if.sv | 37 +++
 rtl/reorder_buffer.sv | 98 +++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: decode/writeback/query/commit bundle of the reorder buffer.
interface reorder_buffer_if #(
  parameter int DEPTH = 8,
  parameter int DATAW = 32,
  parameter int REGW  = 5
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int TAGW = IDXW + 1;
  logic             alloc_en;
  logic [1:0]       alloc_class;
  logic [REGW-1:0]  alloc_dest;
  logic [IDXW-1:0]  rob_tail;
  logic             rob_full;
  logic [TAGW-1:0]  chk_tag1, chk_tag2, chk_tagd;
  logic             chk_ready1, chk_ready2, chk_readyd;
  logic [DATAW-1:0] chk_data1, chk_data2, chk_datad;
  logic             wb_en;
  logic [TAGW-1:0]  wb_tag;
  logic [DATAW-1:0] wb_data;
  logic             flush;
  logic             commit_en;
  logic [REGW-1:0]  commit_addr;
  logic [DATAW-1:0] commit_data;
  logic [TAGW-1:0]  commit_tag;
  modport master (
    output alloc_en, alloc_class, alloc_dest, chk_tag1, chk_tag2, chk_tagd,
           wb_en, wb_tag, wb_data, flush,
    input  rob_tail, rob_full, chk_ready1, chk_ready2, chk_readyd,
           chk_data1, chk_data2, chk_datad, commit_en, commit_addr, commit_data, commit_tag
  );
  modport slave (
    input  alloc_en, alloc_class, alloc_dest, chk_tag1, chk_tag2, chk_tagd,
           wb_en, wb_tag, wb_data, flush,
    output rob_tail, rob_full, chk_ready1, chk_ready2, chk_readyd,
           chk_data1, chk_data2, chk_datad, commit_en, commit_addr, commit_data, commit_tag
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB with in-order retire, tag queries and flush.
// Optional ROB_WB_BYPASS_EN: tag queries also see the same-cycle writeback.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int DATAW = 32,
  parameter int REGW  = 5
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int TAGW = IDXW + 1;
  logic [DEPTH-1:0] r_valid, r_ready;
  logic [1:0]       r_cls  [DEPTH];
  logic [REGW-1:0]  r_dest [DEPTH];
  logic [DATAW-1:0] r_data [DEPTH];
  logic [IDXW-1:0]  r_head, r_tail;
  logic [IDXW:0]    r_count;
  logic             r_commit_en;
  logic [REGW-1:0]  r_commit_addr;
  logic [DATAW-1:0] r_commit_data;
  logic [TAGW-1:0]  r_commit_tag;
  logic             w_full, w_alloc, w_wb, w_commit;
  logic [IDXW-1:0]  w_wb_idx;
  logic [DATAW-1:0] w_wb_data;
  logic [DATAW:0]   w_q1, w_q2, w_qd;
  assign w_full    = r_count == TAGW'(DEPTH);
  assign w_alloc   = bus.alloc_en & ~w_full;
  assign w_wb_idx  = bus.wb_tag[IDXW-1:0];
  assign w_wb_data = bus.wb_data;
  assign w_wb      = bus.wb_en & ~bus.wb_tag[IDXW] & r_valid[w_wb_idx];
  assign w_commit  = r_valid[r_head] & r_ready[r_head];
  // Returns {ready, data}; a tag with MSB set means the value lives in the regfile.
  function automatic logic [DATAW:0] query(input logic [TAGW-1:0] t);
    logic [IDXW-1:0] i;
    i = t[IDXW-1:0];
`ifdef ROB_WB_BYPASS_EN
    if (!t[IDXW] && w_wb && i == w_wb_idx) return {1'b1, w_wb_data};
`endif
    return t[IDXW] ? {1'b1, DATAW'(0)} : (r_valid[i] & r_ready[i]) ? {1'b1, r_data[i]} : '0;
  endfunction
  assign w_q1 = query(bus.chk_tag1);
  assign w_q2 = query(bus.chk_tag2);
  assign w_qd = query(bus.chk_tagd);
  assign {bus.chk_ready1, bus.chk_data1} = w_q1;
  assign {bus.chk_ready2, bus.chk_data2} = w_q2;
  assign {bus.chk_readyd, bus.chk_datad} = w_qd;
  assign bus.rob_tail    = r_tail;
  assign bus.rob_full    = w_full;
  assign bus.commit_en   = r_commit_en;
  assign bus.commit_addr = r_commit_addr;
  assign bus.commit_data = r_commit_data;
  assign bus.commit_tag  = r_commit_tag;
  // Payload is only ever read through valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_wb) r_data[w_wb_idx] <= w_wb_data;
    if (w_alloc) begin
      r_cls[r_tail]  <= bus.alloc_class;
      r_dest[r_tail] <= bus.alloc_dest;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_valid       <= '0;
      r_ready       <= '0;
      r_commit_en   <= 1'b0;
      r_commit_addr <= '0;
      r_commit_data <= '0;
      r_commit_tag  <= {1'b1, IDXW'(0)};
    end else if (bus.flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_commit_en <= 1'b0;
    end else begin
      r_commit_en <= w_commit && r_cls[r_head] == 2'b00 && r_dest[r_head] != '0;
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_commit_addr   <= r_dest[r_head];
        r_commit_data   <= r_data[r_head];
        r_commit_tag    <= {1'b0, r_head};
      end
      if (w_wb) r_ready[w_wb_idx] <= 1'b1;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + TAGW'(w_alloc) - TAGW'(w_commit);
    end
  end
endmodule
